// File: rtl/serial_receiver_if.sv
// Byte stream from the UART receiver to its consumer (stb/ack handshake).
interface serial_receiver_if;
  logic [7:0] out1;
  logic       out1_stb;
  logic       out1_ack;

  modport master (output out1, output out1_stb, input out1_ack);
  modport slave  (input out1, input out1_stb, output out1_ack);
endinterface

// File: rtl/serial_receiver.sv
// UART receive path: 2-flop synchronizer, 8N1 deframer FSM, receive FIFO
// with registered head, and registered rtr flow control.
// Optional macro SERIAL_RECEIVER_PARITY_EN switches the frame to 8E1 and adds
// a parity_err pulse output.
module serial_receiver #(
  parameter int clock_frequency = 50000000,
  parameter int baud_rate       = 115200,
  parameter int fifo_depth_log2 = 4,
  parameter int rtr_margin      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rtr,
  output logic frame_err,
  output logic overflow,
`ifdef SERIAL_RECEIVER_PARITY_EN
  output logic parity_err,
`endif
  serial_receiver_if.master out_if
);
  localparam int BIT   = clock_frequency / baud_rate;
  localparam int HALF  = BIT / 2;
  localparam int CW    = (BIT > 2) ? $clog2(BIT) : 1;
  localparam int AW    = fifo_depth_log2;
  localparam int DEPTH = 1 << AW;
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
`ifdef SERIAL_RECEIVER_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

  // rx is asynchronous; only the second flop is ever looked at
  logic rx_m_q, rx_s_q;

  // Two-flop synchronizer, idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
    end
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            push;
`ifdef SERIAL_RECEIVER_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            parity_err_q, parity_err_d;
`endif

  // Deframer: counts half a bit to the start-bit centre, then whole bits
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = HALF_M1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else if (rx_s_q) state_d = S_IDLE;   // too short: glitch
        else begin
          cnt_d   = BIT_M1;
          idx_d   = 3'd0;
          state_d = S_DATA;
`ifdef SERIAL_RECEIVER_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      S_DATA: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else begin
          shift_d = {rx_s_q, shift_q[7:1]};  // LSB first
          cnt_d   = BIT_M1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef SERIAL_RECEIVER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RECEIVER_PARITY_EN
      S_PARITY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else begin
          cnt_d   = BIT_M1;
          state_d = S_STOP;
          // Even parity: the parity bit equals the XOR of the data bits
          if (rx_s_q != ^shift_q) begin
            par_bad_d    = 1'b1;
            parity_err_d = 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else if (rx_s_q) begin
`ifdef SERIAL_RECEIVER_PARITY_EN
          push = !par_bad_q;
`else
          push = 1'b1;
`endif
          state_d = S_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_BREAK;
        end
      end
      S_BREAK: begin
        // Line held low past the stop bit: wait for it to return to idle
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Deframer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
`ifdef SERIAL_RECEIVER_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // ---------------- FIFO ----------------
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d, avail;
  logic [7:0]    out1_q, out1_d;
  logic          stb_q, stb_d;
  logic          overflow_q, overflow_d;
  logic          rtr_q, rtr_d;
  logic          pop, full, wr_en;

  // Push/pop bookkeeping; the head register only sees bytes already in
  // memory, so a fresh byte reaches out1 one cycle after it is written
  always_comb begin
    pop        = stb_q & out_if.out1_ack;
    full       = (count_q == (AW+1)'(DEPTH));
    wr_en      = push & (!full | pop);
    overflow_d = push & full & !pop;
    wr_ptr_d   = wr_ptr_q + AW'(wr_en);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    avail      = count_q - (AW+1)'(pop);
    stb_d      = (avail != '0);
    out1_d     = stb_d ? mem_q[rd_ptr_d] : out1_q;
    rtr_d      = (DEPTH - int'(count_q)) >= rtr_margin;
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  // FIFO control, head register and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out1_q     <= '0;
      stb_q      <= 1'b0;
      overflow_q <= 1'b0;
      rtr_q      <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out1_q     <= out1_d;
      stb_q      <= stb_d;
      overflow_q <= overflow_d;
      rtr_q      <= rtr_d;
    end
  end

  assign out_if.out1     = out1_q;
  assign out_if.out1_stb = stb_q;
  assign rtr             = rtr_q;
  assign frame_err       = frame_err_q;
  assign overflow        = overflow_q;
`ifdef SERIAL_RECEIVER_PARITY_EN
  assign parity_err      = parity_err_q;
`endif
endmodule
